uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller: accepts one byte per valid/ready handshake and serialises it on `txd` as start bit, 8 data bits LSB first, optional even parity bit and stop bit. It contains the baud timer, frame shift register, bit counting and framing FSM. Its byte source is the transmit-side host logic; `txd` drives the pad directly.

## Interface

- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); legal range 2..65535.
- `PARITY_EN`, default 1: 1 inserts an even parity bit (11-bit frame); 0 omits it (10-bit frame).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `tx_data`  in  8  byte to send; sampled only on a handshake.
- `tx_valid`  in  1  byte offered.
- `tx_ready`  out  1  controller can accept a byte; high only in IDLE.
- `txd`  out  1  serial line, registered; idles high.
- `tx_busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.

## Operation

- Frame bits, in transmission order: 0, d0..d7, parity (= XOR of d0..d7, only if PARITY_EN), 1. `FRAME_BITS` = 10 + PARITY_EN.
- States are IDLE, SEND and DONE.
- **IDLE**
  - `tx_ready`=1, `txd`=1.
  - On `tx_valid && tx_ready`: load the shift register with the frame, LSB = start bit.
  - Clear the baud counter and the bit index, then go to SEND.
- **SEND**
  - `txd` = shift register bit 0, registered.
  - The baud counter runs 0..CLKS_PER_BIT-1; its terminal count is a tick.
  - On a tick: shift right with 1 filled in, bit index +1, baud counter wraps to 0.
  - On the tick where bit index == FRAME_BITS-1: go to DONE.
- **DONE**
  - `tx_done`=1 and `txd`=1 for one cycle, then go to IDLE.
- `tx_valid` is ignored outside IDLE.
- `tx_data` changes after acceptance do not affect the frame in flight.
- Bit index width is 4 bits. The baud counter is sized with $clog2(CLKS_PER_BIT) and never exceeds CLKS_PER_BIT-1.
- Reset (`rst_n`=0 sampled at an edge), including mid-frame: state goes to IDLE, counters to 0 and the shift register to all-ones. The partial frame is abandoned, not completed.

## Timing

- Reset values after the first edge with `rst_n`=0: `txd`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
- `tx_valid` asserted in the reset cycle is not accepted.
- Handshake at edge N: `txd` falls to 0 and `tx_busy` rises after edge N+1.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- The stop bit ends after FRAME_BITS*CLKS_PER_BIT cycles of SEND. `tx_done` is high for the following single cycle.
- `tx_ready` returns high the cycle after `tx_done`.
- Minimum accept-to-accept spacing is FRAME_BITS*CLKS_PER_BIT + 2 cycles.
- `tx_ready` is a combinational decode of state; it does not depend on `tx_valid`.

## Structure

- Shared package `uart_pkg` holds:
  - the state enum (IDLE, SEND, DONE);
  - `DATA_BITS`=8 and the start/stop level constants;
  - an even-parity function, reused by the receive side.
- One sub-module is natural: `uart_baud_tick`. Ports: `clk`, `rst_n`, `clear`, `enable`; output `tick`. It is a modulo-CLKS_PER_BIT counter that pulses `tick` on its terminal count.
- The FSM, shift register and bit index live in `uart_tx_ctrl`.

## Test plan

Use CLKS_PER_BIT=4 unless noted.

- **Reset:** hold `rst_n`=0 for 3 cycles with `tx_valid`=1 -> `txd`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, and no frame starts while in reset.
- **Byte 0x55, PARITY_EN=1:** `txd` sequence, 4 cycles per bit, is 0,1,0,1,0,1,0,1,0,0,1. `tx_done` pulses exactly 44 cycles after `txd` falls.
- **Byte 0x80, PARITY_EN=1:** sequence 0,0,0,0,0,0,0,0,1,1,1 (parity 1).
- **Same byte 0x80, PARITY_EN=0:** 10-bit frame 0,0,0,0,0,0,0,0,1,1, with `tx_done` 40 cycles after the falling edge.
- **Back-to-back:** hold `tx_valid`=1 with 0xA5 then 0x3C. Second acceptance occurs the cycle after `tx_done`. Both frames are correct and `tx_data` changes mid-frame have no effect.
- **Mid-frame reset:** `rst_n`=0 during data bit 3 of 0xFF -> `txd`=1 the next cycle and `tx_ready`=1. A new byte 0x01 afterwards produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: framing constants, transmit FSM states, parity helper.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Modulo-CLKS_PER_BIT counter; tick marks the last cycle of each bit period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CntLast);

    // Next count: clear wins, otherwise count up and wrap on the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CntLast) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned ShiftW    = DATA_BITS + 3;
    localparam int unsigned FrameBits = 10 + PARITY_EN;
    localparam logic [3:0]  LastBit   = 4'(FrameBits - 1);

    tx_state_e         state_q, state_d;
    logic [ShiftW-1:0] shift_q, shift_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              baud_clear, baud_en, baud_tick;
    logic [ShiftW-1:0] frame_load;
    logic              parity_or_stop;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (baud_clear),
        .enable(baud_en),
        .tick  (baud_tick)
    );

    // Frame image, LSB transmitted first; without parity bit 9 is already the stop bit.
    always_comb begin
        parity_or_stop = (PARITY_EN != 0) ? even_parity(tx_data) : STOP_BIT;
        frame_load     = {STOP_BIT, parity_or_stop, tx_data, START_BIT};
    end

    // Next-state, datapath and output decode for the framing FSM.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        txd_d      = STOP_BIT;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        baud_clear = 1'b1;
        baud_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    shift_d   = frame_load;
                    bit_idx_d = '0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                txd_d      = shift_q[0];
                baud_clear = 1'b0;
                baud_en    = 1'b1;
                if (baud_tick) begin
                    shift_d   = {1'b1, shift_q[ShiftW-1:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == LastBit) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                tx_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Busy lags state by one cycle, so it covers the DONE cycle but not the accept cycle.
        busy_d = (state_q == StSend);
    end

    // State, shift register, bit index and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '1;
            bit_idx_q <= '0;
            txd_q     <= STOP_BIT;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (with and without parity) share stimulus and
// are checked every cycle against a cycle-offset model, plus literal frame checks.
module tb_uart_tx_ctrl;

    localparam int C  = 4;
    localparam int LP = 11 * C;  // SEND length with parity
    localparam int LN = 10 * C;  // SEND length without parity

    typedef bit frame_t [11];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    logic ready_p, txd_p, busy_p, done_p;
    logic ready_n, txd_n, busy_n, done_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(C),
        .PARITY_EN   (1)
    ) dut_p (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(ready_p),
        .txd     (txd_p),
        .tx_busy (busy_p),
        .tx_done (done_p)
    );

    uart_tx_ctrl #(
        .CLKS_PER_BIT(C),
        .PARITY_EN   (0)
    ) dut_n (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(ready_n),
        .txd     (txd_n),
        .tx_busy (busy_n),
        .tx_done (done_n)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t = cycles since the accepting edge (-1 when idle). Cycle t shows the
    // wire bit sent (t-1)/C bit-periods into the frame; t == frame length is DONE.
    int         t_p = -1, t_n = -1;
    logic [7:0] d_p = 8'h00, d_n = 8'h00;
    bit         armed = 1'b0;

    function automatic logic exp_txd(input int t, input logic [7:0] d, input bit pe);
        int idx;
        if (t <= 0) return 1'b1;
        idx = (t - 1) / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (pe && idx == 9) return ^d;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            t_p   <= -1;
            t_n   <= -1;
            armed <= 1'b1;
        end else begin
            if (t_p < 0) begin
                if (tx_valid) begin
                    t_p <= 0;
                    d_p <= tx_data;
                end
            end else if (t_p == LP) begin
                t_p <= -1;
            end else begin
                t_p <= t_p + 1;
            end
            if (t_n < 0) begin
                if (tx_valid) begin
                    t_n <= 0;
                    d_n <= tx_data;
                end
            end else if (t_n == LN) begin
                t_n <= -1;
            end else begin
                t_n <= t_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check_bit("m_p_txd", txd_p, exp_txd(t_p, d_p, 1'b1));
            check_bit("m_p_busy", busy_p, (t_p >= 1));
            check_bit("m_p_done", done_p, (t_p == LP));
            check_bit("m_p_ready", ready_p, (t_p < 0));
            check_bit("m_n_txd", txd_n, exp_txd(t_n, d_n, 1'b0));
            check_bit("m_n_busy", busy_n, (t_n >= 1));
            check_bit("m_n_done", done_n, (t_n == LN));
            check_bit("m_n_ready", ready_n, (t_n < 0));
        end
    end

    // Called at a negedge with both instances idle; sends one byte and checks the
    // sampled mid-bit values and the done timing against hand-written frames.
    task automatic send_frame(input string tag, input logic [7:0] d,
                              input frame_t exp_p, input frame_t exp_n);
        int dt_p = -1;
        int dt_n = -1;
        check_bit({tag, "_ready_before"}, ready_p, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        check_bit({tag, "_accepted"}, ready_p, 1'b0);
        for (int k = 1; k <= LP; k++) begin
            @(negedge clk);
            if (k % C == 2) begin
                check_bit($sformatf("%s_p_bit%0d", tag, (k - 1) / C), txd_p,
                          exp_p[(k-1)/C]);
                if (k <= LN) begin
                    check_bit($sformatf("%s_n_bit%0d", tag, (k - 1) / C), txd_n,
                              exp_n[(k-1)/C]);
                end
            end
            if (done_p && dt_p < 0) dt_p = k;
            if (done_n && dt_n < 0) dt_n = k;
        end
        // txd is first low at k=1, so done at k=44 (40) is the 44th (40th) wire cycle.
        check_int({tag, "_p_done_cycle"}, dt_p, LP);
        check_int({tag, "_n_done_cycle"}, dt_n, LN);
        @(negedge clk);
    endtask

    initial begin
        int w;
        // Reset with tx_valid high: nothing may start.
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_bit("rst_txd_p", txd_p, 1'b1);
            check_bit("rst_ready_p", ready_p, 1'b1);
            check_bit("rst_busy_p", busy_p, 1'b0);
            check_bit("rst_done_p", done_p, 1'b0);
            check_bit("rst_txd_n", txd_n, 1'b1);
            check_bit("rst_busy_n", busy_n, 1'b0);
        end
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_bit("post_rst_txd_p", txd_p, 1'b1);

        send_frame("b55", 8'h55, '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1},
                   '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1});
        send_frame("b80", 8'h80, '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1},
                   '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1});

        // Back-to-back with tx_valid held; data changes while frames are in flight.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h3C;
        w = 0;
        while (!done_p && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_bit("b2b_done_seen", done_p, 1'b1);
        check_bit("b2b_ready_in_done", ready_p, 1'b0);
        @(negedge clk);
        check_bit("b2b_ready_after_done", ready_p, 1'b1);
        @(negedge clk);
        check_bit("b2b_second_accepted", ready_p, 1'b0);
        check_bit("b2b_second_t0_txd", txd_p, 1'b1);
        tx_valid = 1'b0;
        tx_data  = 8'hC3;
        @(negedge clk);
        check_bit("b2b_second_start", txd_p, 1'b0);
        repeat (60) @(negedge clk);

        // Mid-frame reset during data bit 3 of 0xFF.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (18) @(negedge clk);
        check_bit("mid_d3_txd", txd_p, 1'b1);
        check_bit("mid_busy", busy_p, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_bit("mid_rst_txd_p", txd_p, 1'b1);
        check_bit("mid_rst_ready_p", ready_p, 1'b1);
        check_bit("mid_rst_busy_p", busy_p, 1'b0);
        check_bit("mid_rst_ready_n", ready_n, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame("b01", 8'h01, '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1},
                   '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1});
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
